hyperspace_pad_stream_bridge: RTL and testbench

Pad-side adapter between the Caravel mprj_io[37:8] pins and the HyperSpace core AXI4-Stream ports, inside the user project wrapper.
- Input path: unpacks the bit-reversed 8-bit pin stream through a registered ingress stage and small FIFO into a core slave stream.
- Output path: buffers the core's 16-bit master stream and drives it onto pins with registered valid/data/last.
- Also: generates io_oeb for the pin map, checks frame lengths against tlast, flags protocol errors.

---
 rtl/hyperspace_pad_stream_bridge_pkg.sv | 44 ++++
 rtl/hyperspace_pad_stream_bridge_fifo.sv | 47 ++++
 rtl/hyperspace_pad_stream_bridge.sv | 156 +++++++++++++++
 tb/tb_hyperspace_pad_stream_bridge.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperspace_pad_stream_bridge_pkg.sv
// Shared definitions for the HyperSpace pad-side stream bridge.
// Pin numbers are Caravel mprj_io numbers; IDX_* are the matching bit
// positions in the 30-bit io_in/io_out/io_oeb vectors (index 0 = pin 8).
package hyperspace_pad_stream_bridge_pkg;

  localparam int IO_W     = 30;
  localparam int PIN_BASE = 8;

  localparam int PIN_IN_DATA_LO  = 30;  // pin 30 carries bit 7, pin 37 bit 0
  localparam int PIN_IN_LAST     = 29;
  localparam int PIN_IN_VALID    = 28;
  localparam int PIN_IN_READY    = 27;
  localparam int PIN_OUT_READY   = 26;
  localparam int PIN_OUT_VALID   = 25;
  localparam int PIN_OUT_LAST    = 24;
  localparam int PIN_OUT_DATA_LO = 8;   // pins 23:8 = out_data[15:0]

  localparam int IDX_IN_DATA_LO  = PIN_IN_DATA_LO  - PIN_BASE;
  localparam int IDX_IN_LAST     = PIN_IN_LAST     - PIN_BASE;
  localparam int IDX_IN_VALID    = PIN_IN_VALID    - PIN_BASE;
  localparam int IDX_IN_READY    = PIN_IN_READY    - PIN_BASE;
  localparam int IDX_OUT_READY   = PIN_OUT_READY   - PIN_BASE;
  localparam int IDX_OUT_VALID   = PIN_OUT_VALID   - PIN_BASE;
  localparam int IDX_OUT_LAST    = PIN_OUT_LAST    - PIN_BASE;
  localparam int IDX_OUT_DATA_LO = PIN_OUT_DATA_LO - PIN_BASE;

  // Driven pins (27, 25:8) have oeb=0; every other pin is an input.
  localparam logic [IO_W-1:0] OEB_MASK = 30'h3FF4_0000;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } in_beat_t;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } out_beat_t;

  function automatic logic [7:0] bit_rev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) bit_rev8[i] = v[7-i];
  endfunction

endpackage

// File: rtl/hyperspace_pad_stream_bridge_fifo.sv
// hps_sync_fifo: single-clock FIFO with first-word fall-through read port.
// Ports: clock, RSTB (sync, active-high), push/wdata, pop/rdata,
// count (entries held), full, empty. A push on a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is ignored.
module hps_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             RSTB,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (RSTB) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/hyperspace_pad_stream_bridge.sv
// Pad-side adapter between mprj_io[37:8] and the HyperSpace core streams.
// Input path : pins -> ingress register (bit order fixed) -> input FIFO -> m_axis.
// Output path: s_axis -> output FIFO -> registered out_valid/last/data -> pins.
// Ports: clock, RSTB (sync, active-high), io_in/io_out/io_oeb (pin vectors),
// m_axis_* (to core), s_axis_* (from core), sticky error flags.
module hyperspace_pad_stream_bridge
  import hyperspace_pad_stream_bridge_pkg::*;
#(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int IN_FRAME  = 2048,
  parameter int OUT_FRAME = 1536
) (
  input  logic              clock,
  input  logic              RSTB,
  input  logic [IO_W-1:0]   io_in,
  output logic [IO_W-1:0]   io_out,
  output logic [IO_W-1:0]   io_oeb,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [15:0]       s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              err_overflow,
  output logic              err_in_last,
  output logic              err_out_last
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int IFW = $clog2(IN_FRAME);
  localparam int OFW = $clog2(OUT_FRAME);
  localparam logic [IAW:0]   IN_READY_MAX = (IAW+1)'(IN_DEPTH - 3);
  localparam logic [IFW-1:0] IN_LAST_CNT  = IFW'(IN_FRAME - 1);
  localparam logic [OFW-1:0] OUT_LAST_CNT = OFW'(OUT_FRAME - 1);

  // ---------------- input path ----------------
  logic     ing_valid;
  in_beat_t ing_beat, in_head;
  logic [IAW:0] in_count, in_count_next;
  logic     in_full, in_empty, in_pop, in_acc, in_ready;
  logic [IFW-1:0] in_frm;

  // Captured whenever the source asserts valid; in_ready is advisory only.
  always_ff @(posedge clock) begin
    if (RSTB) begin
      ing_valid <= 1'b0;
      ing_beat  <= '0;
    end else begin
      ing_valid     <= io_in[IDX_IN_VALID];
      ing_beat.last <= io_in[IDX_IN_LAST];
      ing_beat.data <= bit_rev8(io_in[IDX_IN_DATA_LO +: 8]);
    end
  end

  assign in_pop = m_axis_tvalid && m_axis_tready;
  assign in_acc = ing_valid && (!in_full || in_pop);
  assign in_count_next = in_count + {{IAW{1'b0}}, in_acc} - {{IAW{1'b0}}, in_pop};

  hps_sync_fifo #(.WIDTH(9), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clock (clock),
    .RSTB  (RSTB),
    .push  (ing_valid),
    .wdata (ing_beat),
    .pop   (in_pop),
    .rdata (in_head),
    .count (in_count),
    .full  (in_full),
    .empty (in_empty)
  );

  assign m_axis_tvalid = !in_empty;
  assign m_axis_tdata  = in_head.data;
  assign m_axis_tlast  = in_head.last;

  // Three free slots cover the beat in the ingress register plus the beat
  // the source may launch before it sees in_ready fall.
  always_ff @(posedge clock) begin
    if (RSTB) begin
      in_ready     <= 1'b0;
      in_frm       <= '0;
      err_overflow <= 1'b0;
      err_in_last  <= 1'b0;
    end else begin
      in_ready <= (in_count_next <= IN_READY_MAX);
      if (ing_valid && !in_acc) err_overflow <= 1'b1;
      if (in_acc) begin
        if (ing_beat.last != (in_frm == IN_LAST_CNT)) err_in_last <= 1'b1;
        if (ing_beat.last || in_frm == IN_LAST_CNT) in_frm <= '0;
        else                                        in_frm <= in_frm + 1'b1;
      end
    end
  end

  // ---------------- output path ----------------
  out_beat_t out_head, out_reg;
  logic      out_valid, out_full, out_empty, out_load, out_push;
  logic [OAW:0]   out_count_unused;
  logic [OFW-1:0] out_frm;

  assign s_axis_tready = !RSTB && !out_full;
  assign out_push      = s_axis_tvalid && s_axis_tready;
  // Output register refills when empty or when its beat transfers this edge.
  assign out_load      = !out_valid || io_in[IDX_OUT_READY];

  hps_sync_fifo #(.WIDTH(17), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clock (clock),
    .RSTB  (RSTB),
    .push  (out_push),
    .wdata ({s_axis_tlast, s_axis_tdata}),
    .pop   (out_load),
    .rdata (out_head),
    .count (out_count_unused),
    .full  (out_full),
    .empty (out_empty)
  );

  always_ff @(posedge clock) begin
    if (RSTB) begin
      out_valid    <= 1'b0;
      out_reg      <= '0;
      out_frm      <= '0;
      err_out_last <= 1'b0;
    end else begin
      if (out_load) begin
        out_valid <= !out_empty;
        if (!out_empty) out_reg <= out_head;
      end
      if (out_push) begin
        if (s_axis_tlast != (out_frm == OUT_LAST_CNT)) err_out_last <= 1'b1;
        if (s_axis_tlast || out_frm == OUT_LAST_CNT) out_frm <= '0;
        else                                         out_frm <= out_frm + 1'b1;
      end
    end
  end

  // ---------------- pins ----------------
  always_comb begin
    io_out = '0;
    io_out[IDX_IN_READY]            = in_ready;
    io_out[IDX_OUT_VALID]           = out_valid;
    io_out[IDX_OUT_LAST]            = out_reg.last;
    io_out[IDX_OUT_DATA_LO +: 16]   = out_reg.data;
  end

  assign io_oeb = OEB_MASK;

  // Pins that are outputs have no meaningful input value.
  logic unused_pins;
  assign unused_pins = ^{io_in[IDX_IN_READY], io_in[IDX_OUT_VALID],
                         io_in[IDX_OUT_LAST], io_in[IDX_OUT_DATA_LO +: 16]};

endmodule

// File: tb/tb_hyperspace_pad_stream_bridge.sv
module tb_hyperspace_pad_stream_bridge;

  logic        clock = 1'b0;
  logic        RSTB  = 1'b1;
  logic [29:0] io_in, io_out, io_oeb;
  logic        m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
  logic [7:0]  m_axis_tdata;
  logic        s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [15:0] s_axis_tdata = '0;
  logic        err_overflow, err_in_last, err_out_last;

  // Raw pin drives; pin_raw[k] is the level on pin 30+k.
  logic [7:0]  pin_raw    = '0;
  logic        pin_last   = 1'b0;
  logic        pin_valid  = 1'b0;
  logic        pin_oready = 1'b0;
  logic [17:0] pin_junk   = '0;
  logic        pin_j27    = 1'b0;

  assign io_in = {pin_raw, pin_last, pin_valid, pin_j27, pin_oready, pin_junk};

  always #5 clock = ~clock;

  hyperspace_pad_stream_bridge dut (
    .clock(clock), .RSTB(RSTB), .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .err_overflow(err_overflow), .err_in_last(err_in_last), .err_out_last(err_out_last)
  );

  int n_tests = 0, n_fail = 0;
  int in_seen = 0, out_seen = 0;
  logic [8:0]  q_in[$];
  logic [16:0] q_out[$];
  logic        tog_run = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Pin 30 carries data bit 7, pin 37 carries bit 0.
  function automatic logic [7:0] to_pins(input logic [7:0] b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = b[7-k];
    return r;
  endfunction

  // Scoreboard monitors: sample mid-cycle; a handshake seen here transfers
  // at the next rising edge.
  always @(negedge clock) begin
    if (!RSTB && m_axis_tvalid && m_axis_tready) begin
      in_seen++;
      if (q_in.size() == 0) chk("in_extra_beat", {23'd0, m_axis_tlast, m_axis_tdata}, 32'hDEAD);
      else chk("in_beat", {23'd0, m_axis_tlast, m_axis_tdata}, {23'd0, q_in.pop_front()});
    end
    if (!RSTB && io_out[17] && pin_oready) begin
      out_seen++;
      if (q_out.size() == 0) chk("out_extra_beat", {15'd0, io_out[16:0]}, 32'hDEAD);
      else chk("out_beat", {15'd0, io_out[16:0]}, {15'd0, q_out.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset(input int n);
    tick();
    RSTB = 1'b1;
    pin_valid = 1'b0; pin_oready = 1'b0; m_axis_tready = 1'b0; s_axis_tvalid = 1'b0;
    repeat (n) tick();
    q_in.delete(); q_out.delete();
    in_seen = 0; out_seen = 0;
    RSTB = 1'b0;
  endtask

  task automatic drive_in(input logic v, input logic [7:0] b, input logic l);
    tick();
    pin_valid = v; pin_raw = to_pins(b); pin_last = l;
  endtask

  task automatic core_send(input int n, input int last_at);
    int i = 0, guard = 0;
    while (i < n && guard < 20000) begin
      tick();
      s_axis_tvalid = 1'b1; s_axis_tdata = i[15:0]; s_axis_tlast = (i == last_at);
      @(negedge clock);
      if (s_axis_tready) begin
        q_out.push_back({s_axis_tlast, s_axis_tdata});
        i++;
      end
      guard++;
    end
    tick();
    s_axis_tvalid = 1'b0;
    chk("core_send_done", i, n);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, guard;

    // ---- reset with pins toggling ----
    RSTB = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      pin_raw = 8'($urandom); pin_last = 1'($urandom); pin_valid = 1'($urandom);
      pin_oready = 1'($urandom); pin_junk = 18'($urandom); pin_j27 = 1'($urandom);
      m_axis_tready = 1'($urandom); s_axis_tvalid = 1'($urandom);
      @(negedge clock);
      chk("rst_oeb", io_oeb, 32'h3FF4_0000);
      chk("rst_io_out", io_out, 0);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_flags", {err_overflow, err_in_last, err_out_last}, 0);
    end
    pin_junk = '0; pin_j27 = 1'b0;
    do_reset(2);

    // ---- single beat, bit reversal and 2-cycle latency ----
    m_axis_tready = 1'b1;
    tick();
    pin_raw = 8'b0000_0001; pin_valid = 1'b1; pin_last = 1'b0;
    q_in.push_back(9'h080);
    tick();
    pin_valid = 1'b0;
    @(negedge clock); chk("lat_cycle1_tvalid", m_axis_tvalid, 0);
    @(negedge clock); chk("lat_cycle2_tvalid", m_axis_tvalid, 1);
                      chk("lat_cycle2_tdata", m_axis_tdata, 8'h80);
    @(negedge clock); chk("lat_cycle3_tvalid", m_axis_tvalid, 0);
    chk("io_oeb_run", io_oeb, 32'h3FF4_0000);

    // ---- stalled core, source obeys in_ready ----
    do_reset(2);
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (io_out[19]) begin
        pin_valid = 1'b1; pin_raw = to_pins(8'h30 + 8'(sent)); pin_last = 1'b0;
        q_in.push_back({1'b0, 8'h30 + 8'(sent)});
        sent++;
      end else pin_valid = 1'b0;
    end
    tick(); pin_valid = 1'b0;
    chk("flow_sent_bounded", (sent >= 1 && sent <= 4), 1);
    chk("flow_in_ready_low", io_out[19], 0);
    chk("flow_no_overflow", err_overflow, 0);
    m_axis_tready = 1'b1;
    repeat (sent) @(negedge clock);
    tick();
    chk("flow_drained_1pc", q_in.size(), 0);
    chk("flow_tvalid_after", m_axis_tvalid, 0);

    // ---- source ignores in_ready into stalled core ----
    do_reset(2);
    for (int b = 0; b < 8; b++) begin
      drive_in(1'b1, 8'hA0 + 8'(b), 1'b0);
      if (b < 4) q_in.push_back({1'b0, 8'hA0 + 8'(b)});
    end
    drive_in(1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    chk("ovf_flag", err_overflow, 1);
    m_axis_tready = 1'b1;
    repeat (10) tick();
    chk("ovf_delivered", in_seen, 4);
    chk("ovf_queue_empty", q_in.size(), 0);
    chk("ovf_sticky", err_overflow, 1);

    // ---- input frames ----
    do_reset(2);
    m_axis_tready = 1'b1;
    for (int b = 0; b < 2048; b++) begin
      drive_in(1'b1, 8'(b * 7), b == 2047);
      q_in.push_back({b == 2047, 8'(b * 7)});
    end
    drive_in(1'b0, 8'h00, 1'b0);
    repeat (5) tick();
    chk("frame_in_good_err", err_in_last, 0);
    chk("frame_in_no_ovf", err_overflow, 0);
    chk("frame_in_all_seen", in_seen, 2048);
    for (int b = 0; b <= 100; b++) begin
      drive_in(1'b1, 8'(b), b == 100);
      q_in.push_back({b == 100, 8'(b)});
    end
    drive_in(1'b0, 8'h00, 1'b0);
    repeat (5) tick();
    chk("frame_in_short_err", err_in_last, 1);
    chk("frame_in_short_q", q_in.size(), 0);

    // ---- output frame with toggling out_ready ----
    do_reset(2);
    tog_run = 1'b1;
    fork
      core_send(1536, 1535);
      while (tog_run) begin
        tick();
        pin_oready = 1'($urandom);
      end
      begin
        guard = 0;
        wait (q_out.size() != 0);
        while ((q_out.size() != 0 || out_seen < 1536) && guard < 10000) begin
          tick(); guard++;
        end
        chk("out_drain_timeout", (guard < 10000), 1);
        tog_run = 1'b0;
      end
    join
    chk("out_count", out_seen, 1536);
    chk("out_queue_empty", q_out.size(), 0);
    chk("out_good_err", err_out_last, 0);

    // ---- short output frame ----
    pin_oready = 1'b1;
    core_send(6, 5);
    repeat (8) tick();
    chk("out_short_err", err_out_last, 1);
    chk("out_short_q", q_out.size(), 0);

    // ---- mid-operation reset clears flags ----
    do_reset(2);
    tick();
    chk("rst_clears_flags", {err_overflow, err_in_last, err_out_last}, 0);
    chk("rst_clears_out", io_out[17], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
